// File: rtl/imm_extend_pipe_if.sv
// imm_extend_pipe_if
//   Handshake bundle for the immediate-extension stage.
//   Input side : in_valid/in_ready with in_imm (IN_W) and in_mode (2).
//   Output side: out_valid/out_ready with out_data (OUT_W) and out_neg.
//   slave  : the extension stage itself.
//   master : the environment (decode producer + operand consumer).
interface imm_extend_pipe_if #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_neg;

    modport slave (
        input  in_valid, in_imm, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_neg
    );

    modport master (
        output in_valid, in_imm, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_neg
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe
//   Registered immediate-extension stage with a 2-entry skid buffer.
//   Modes: 00 sign-extend, 01 zero-extend, 10 sign-extend then shift left
//   by SHAMT, 11 immediate placed in the upper IN_W bits.
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : imm_extend_pipe_if.slave (in_* handshake + immediate/mode,
//            out_* handshake + extended data and its sign bit)
module imm_extend_pipe #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 16,
    parameter int SHAMT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    imm_extend_pipe_if.slave      bus
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t           state, state_nx;
    logic [OUT_W-1:0] out_q, skid_q, ext_in, out_nx;
    logic             neg_q;
    logic             accept, drain;
    logic             load_out, load_skid, from_skid;

    // Extension is done before registering so both entries hold finished
    // operands; a later mode change cannot touch stored items.
    function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] imm,
                                                input logic [1:0]      mode);
        logic [OUT_W-1:0] sx, zx;
        sx = OUT_W'($signed(imm));
        zx = OUT_W'(imm);
        case (mode)
            2'b00:   extend = sx;
            2'b01:   extend = zx;
            2'b10:   extend = sx << SHAMT;
            default: extend = zx << (OUT_W - IN_W);
        endcase
    endfunction

    assign ext_in = extend(bus.in_imm, bus.in_mode);

    // in_ready depends on state only, so out_ready never reaches it
    // combinationally.
    assign bus.in_ready  = (state != FULL);
    assign bus.out_valid = (state != EMPTY);
    assign bus.out_data  = out_q;
    assign bus.out_neg   = neg_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign drain  = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        load_out  = 1'b0;
        load_skid = 1'b0;
        from_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    load_out = 1'b1;
                    state_nx = ONE;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_nx  = FULL;
                end else if (drain) begin
                    state_nx  = EMPTY;
                end
            end
            FULL: begin
                if (drain) begin
                    load_out  = 1'b1;
                    from_skid = 1'b1;
                    state_nx  = ONE;
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

    assign out_nx = from_skid ? skid_q : ext_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            neg_q  <= 1'b0;
            skid_q <= '0;
        end else begin
            if (load_out) begin
                out_q <= out_nx;
                neg_q <= out_nx[OUT_W-1];
            end
            if (load_skid) skid_q <= ext_in;
        end
    end
endmodule

// File: tb/tb_imm_extend_pipe.sv
module tb_imm_extend_pipe;
    localparam int IW = 4, OW = 16, SH = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imm_extend_pipe_if #(.IN_W(IW), .OUT_W(OW)) bus ();
    imm_extend_pipe #(.IN_W(IW), .OUT_W(OW), .SHAMT(SH)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));

    imm_extend_pipe_if #(.IN_W(8), .OUT_W(16)) bus2 ();
    imm_extend_pipe #(.IN_W(8), .OUT_W(16), .SHAMT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2));

    int errors = 0;
    int checks = 0;
    logic [15:0] q[$];     // items expected in the stage, oldest first
    logic [15:0] got[$];   // values seen leaving the stage

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: integer arithmetic on the immediate value.
    function automatic logic [15:0] ref_ext(input logic [3:0] imm, input logic [1:0] md);
        longint v, s, r;
        v = longint'(imm);
        s = (v >= (1 << (IW - 1))) ? v - (1 << IW) : v;
        case (md)
            2'd0:    r = s;
            2'd1:    r = v;
            2'd2:    r = s * (1 << SH);
            default: r = v * (1 << (OW - IW));
        endcase
        r = r & ((longint'(1) << OW) - 1);
        return r[15:0];
    endfunction

    // Called at a negedge: drive, check against model, advance one clock.
    task automatic cyc(input logic iv, input logic [3:0] imm, input logic [1:0] md,
                       input logic ordy, output logic acc);
        bus.in_valid  = iv;
        bus.in_imm    = imm;
        bus.in_mode   = md;
        bus.out_ready = ordy;
        #1;
        chk("out_valid", bus.out_valid, q.size() != 0);
        chk("in_ready", bus.in_ready, q.size() < 2);
        if (q.size() != 0) begin
            chk("out_data", bus.out_data, q[0]);
            chk("out_neg", bus.out_neg, q[0][15]);
        end
        acc = iv && (q.size() < 2);
        if (q.size() != 0 && ordy) got.push_back(q.pop_front());
        if (acc) q.push_back(ref_ext(imm, md));
        @(posedge clk);
        @(negedge clk);
    endtask

    // One item into a stage that will present it next cycle; constant expectation.
    task automatic dir(input string tag, input logic [3:0] imm, input logic [1:0] md,
                       input logic [15:0] exp, input logic neg);
        logic a;
        cyc(1'b1, imm, md, 1'b1, a);
        chk({tag, "_valid"}, bus.out_valid, 1'b1);
        chk(tag, bus.out_data, exp);
        chk({tag, "_neg"}, bus.out_neg, neg);
    endtask

    initial begin
        logic a;
        logic pv;
        logic [3:0] pimm;
        logic [1:0] pmd;

        bus.in_valid = 0; bus.in_imm = 0; bus.in_mode = 0; bus.out_ready = 0;
        bus2.in_valid = 0; bus2.in_imm = 0; bus2.in_mode = 0; bus2.out_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_data", bus.out_data, 16'h0000);
        chk("rst_out_neg", bus.out_neg, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        // Sign-extend stream, back to back, 1-cycle latency each
        dir("sext_7", 4'b0111, 2'd0, 16'h0007, 1'b0);
        dir("sext_8", 4'b1000, 2'd0, 16'hFFF8, 1'b1);
        dir("sext_2", 4'b0010, 2'd0, 16'h0002, 1'b0);
        dir("sext_0", 4'b0000, 2'd0, 16'h0000, 1'b0);
        dir("sext_f", 4'b1111, 2'd0, 16'hFFFF, 1'b1);
        dir("zext_8", 4'b1000, 2'd1, 16'h0008, 1'b0);
        dir("zext_f", 4'b1111, 2'd1, 16'h000F, 1'b0);
        dir("upper_a", 4'b1010, 2'd3, 16'hA000, 1'b1);
        dir("upper_1", 4'b0001, 2'd3, 16'h1000, 1'b0);
        dir("shl_8", 4'b1000, 2'd2, 16'hFFF0, 1'b1);
        dir("shl_7", 4'b0111, 2'd2, 16'h000E, 1'b0);
        cyc(1'b0, 4'd0, 2'd0, 1'b1, a);

        // Backpressure: two accepted, third held until space frees
        got.delete();
        cyc(1'b1, 4'b1000, 2'd0, 1'b0, a);
        cyc(1'b1, 4'b0111, 2'd1, 1'b0, a);
        chk("bp_in_ready_low", bus.in_ready, 1'b0);
        cyc(1'b1, 4'b0011, 2'd0, 1'b0, a);
        chk("bp_held_data", bus.out_data, 16'hFFF8);
        cyc(1'b1, 4'b0011, 2'd0, 1'b1, a);
        chk("bp_not_taken_while_full", a, 1'b0);
        cyc(1'b1, 4'b0011, 2'd0, 1'b1, a);
        chk("bp_third_taken", a, 1'b1);
        cyc(1'b0, 4'd0, 2'd0, 1'b1, a);
        cyc(1'b0, 4'd0, 2'd0, 1'b1, a);
        chk("bp_count", got.size(), 3);
        if (got.size() == 3) begin
            chk("bp_order0", got[0], 16'hFFF8);
            chk("bp_order1", got[1], 16'h0007);
            chk("bp_order2", got[2], 16'h0003);
        end

        // Full throughput: 8 items, one output every cycle
        got.delete();
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 4'(i * 3 + 1), 2'(i), 1'b1, a);
            chk("tp_in_ready", bus.in_ready, 1'b1);
            chk("tp_out_valid", bus.out_valid, 1'b1);
        end
        cyc(1'b0, 4'd0, 2'd0, 1'b1, a);
        chk("tp_count", got.size(), 8);

        // Reset while FULL, asserted mid-cycle
        cyc(1'b1, 4'b1001, 2'd0, 1'b0, a);
        cyc(1'b1, 4'b0101, 2'd1, 1'b0, a);
        chk("rf_full", bus.in_ready, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("rf_out_valid", bus.out_valid, 1'b0);
        chk("rf_out_data", bus.out_data, 16'h0000);
        chk("rf_in_ready", bus.in_ready, 1'b1);
        q.delete();
        got.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 4'b1010, 2'd1, 1'b1, a);
        cyc(1'b0, 4'd0, 2'd0, 1'b1, a);
        cyc(1'b0, 4'd0, 2'd0, 1'b1, a);
        chk("rf_single", got.size(), 1);
        if (got.size() == 1) chk("rf_value", got[0], 16'h000A);

        // Randomised traffic; producer holds an item until it is taken
        pv = 1'b0; pimm = '0; pmd = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pv) begin
                pv   = ($urandom_range(0, 3) != 0);
                pimm = 4'($urandom);
                pmd  = 2'($urandom);
            end
            cyc(pv, pimm, pmd, ($urandom_range(0, 2) != 0), a);
            if (a) pv = 1'b0;
        end
        for (int i = 0; i < 3; i++) cyc(1'b0, 4'd0, 2'd0, 1'b1, a);
        chk("rand_drained", q.size(), 0);

        // Wider configuration: IN_W=8, SHAMT=2
        bus2.in_valid = 1; bus2.in_imm = 8'h80; bus2.in_mode = 2'd2; bus2.out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        bus2.in_valid = 0;
        chk("w8_valid", bus2.out_valid, 1'b1);
        chk("w8_shl", bus2.out_data, 16'hFE00);
        chk("w8_neg", bus2.out_neg, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
